// File: rtl/el2_pkg.sv
// Shared types and encodings for the AXI4-to-AHB-Lite master bridge.
package el2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } axi2ahb_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] HTRANS_IDLE     = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

endpackage

// File: rtl/axi4_to_ahb_master.sv
// AXI4 slave port to AHB-Lite master port bridge.
// Single-beat transfers, one outstanding command, 64-bit data on both sides.
// Optional feature: define AXI2AHB_POSTED_WR_EN to return the write response
// as soon as the AHB address phase is accepted; AHB errors on such writes are
// then reported through the sticky ahb_wr_err flag.
module axi4_to_ahb_master
   import el2_pkg::*;
#(
   parameter int TAG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bus_clk_en,

   input  logic            axi_awvalid,
   output logic            axi_awready,
   input  logic [TAG-1:0]  axi_awid,
   input  logic [31:0]     axi_awaddr,
   input  logic [2:0]      axi_awsize,
   input  logic [7:0]      axi_awlen,

   input  logic            axi_wvalid,
   output logic            axi_wready,
   input  logic [63:0]     axi_wdata,
   input  logic [7:0]      axi_wstrb,
   input  logic            axi_wlast,

   output logic            axi_bvalid,
   input  logic            axi_bready,
   output logic [TAG-1:0]  axi_bid,
   output logic [1:0]      axi_bresp,

   input  logic            axi_arvalid,
   output logic            axi_arready,
   input  logic [TAG-1:0]  axi_arid,
   input  logic [31:0]     axi_araddr,
   input  logic [2:0]      axi_arsize,
   input  logic [7:0]      axi_arlen,

   output logic            axi_rvalid,
   input  logic            axi_rready,
   output logic [TAG-1:0]  axi_rid,
   output logic [63:0]     axi_rdata,
   output logic [1:0]      axi_rresp,
   output logic            axi_rlast,

   output logic [31:0]     ahb_haddr,
   output logic [2:0]      ahb_hsize,
   output logic [1:0]      ahb_htrans,
   output logic            ahb_hwrite,
   output logic [2:0]      ahb_hburst,
   output logic [3:0]      ahb_hprot,
   output logic            ahb_hmastlock,
   output logic [63:0]     ahb_hwdata,
   input  logic [63:0]     ahb_hrdata,
   input  logic            ahb_hready,
   input  logic            ahb_hresp,
   output logic            ahb_wr_err
);

   axi2ahb_state_t   state_q, state_d;
   logic             last_was_write_q, last_was_write_d;
   logic [TAG-1:0]   id_q, id_d;
   logic [31:0]      addr_q, addr_d;
   logic [1:0]       size_q, size_d;
   logic             write_q, write_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      rdata_q, rdata_d;
   logic [1:0]       resp_q, resp_d;
   logic             err_seen_q, err_seen_d;
`ifdef AXI2AHB_POSTED_WR_EN
   logic             bvalid_post_q, bvalid_post_d;
   logic             wr_err_q, wr_err_d;
`endif

   logic             wr_eligible;
   logic             rd_eligible;
   logic             cmd_free;
   logic             pick_write;
   logic             accept_wr;
   logic             accept_rd;
   logic             bvalid_int;
   logic             rvalid_int;
   logic             b_hs;
   logic             r_hs;
   logic             unused_size_msb;

   // AHB sizes above a doubleword cannot occur on a 64-bit bus; only size[1:0] is kept.
   assign unused_size_msb = axi_awsize[2] ^ axi_arsize[2];

   // Command arbitration: a write needs both AW and W; ties alternate between write and read.
   assign wr_eligible = axi_awvalid & axi_wvalid;
   assign rd_eligible = axi_arvalid;
`ifdef AXI2AHB_POSTED_WR_EN
   assign cmd_free    = bus_clk_en & (state_q == IDLE) & ~bvalid_post_q;
`else
   assign cmd_free    = bus_clk_en & (state_q == IDLE);
`endif
   assign pick_write  = wr_eligible & (~rd_eligible | ~last_was_write_q);
   assign accept_wr   = cmd_free & pick_write;
   assign accept_rd   = cmd_free & rd_eligible & ~pick_write;

   assign axi_awready = accept_wr;
   assign axi_wready  = accept_wr;
   assign axi_arready = accept_rd;

   // Response valids come straight from state so they stay stable while bus_clk_en is low.
`ifdef AXI2AHB_POSTED_WR_EN
   assign bvalid_int  = ((state_q == RESP) & write_q) | bvalid_post_q;
   assign ahb_wr_err  = wr_err_q;
`else
   assign bvalid_int  = (state_q == RESP) & write_q;
   assign ahb_wr_err  = 1'b0;
`endif
   assign rvalid_int  = (state_q == RESP) & ~write_q;
   assign b_hs        = bvalid_int & axi_bready & bus_clk_en;
   assign r_hs        = rvalid_int & axi_rready & bus_clk_en;

   assign axi_bvalid  = bvalid_int;
   assign axi_bid     = id_q;
   assign axi_bresp   = resp_q;
   assign axi_rvalid  = rvalid_int;
   assign axi_rid     = id_q;
   assign axi_rdata   = rdata_q;
   assign axi_rresp   = resp_q;
   assign axi_rlast   = 1'b1;

   assign ahb_htrans    = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ahb_haddr     = addr_q;
   assign ahb_hsize     = {1'b0, size_q};
   assign ahb_hwrite    = write_q;
   assign ahb_hwdata    = wdata_q;
   assign ahb_hburst    = 3'b000;
   assign ahb_hprot     = 4'b0011;
   assign ahb_hmastlock = 1'b0;

   // Next-state and capture logic; nothing advances while bus_clk_en is low.
   always_comb begin
      state_d          = state_q;
      last_was_write_d = last_was_write_q;
      id_d             = id_q;
      addr_d           = addr_q;
      size_d           = size_q;
      write_d          = write_q;
      wdata_d          = wdata_q;
      rdata_d          = rdata_q;
      resp_d           = resp_q;
      err_seen_d       = err_seen_q;
`ifdef AXI2AHB_POSTED_WR_EN
      bvalid_post_d    = bvalid_post_q;
      wr_err_d         = wr_err_q;
      if (b_hs) begin
         bvalid_post_d = 1'b0;
      end
`endif
      if (bus_clk_en) begin
         case (state_q)
            IDLE: begin
               if (accept_wr || accept_rd) begin
                  last_was_write_d = accept_wr;
                  write_d          = accept_wr;
                  err_seen_d       = 1'b0;
                  resp_d           = AXI_RESP_OKAY;
                  if (accept_wr) begin
                     id_d    = axi_awid;
                     addr_d  = axi_awaddr;
                     size_d  = axi_awsize[1:0];
                     wdata_d = axi_wdata;
                     // Malformed bursts are refused; an all-zero strobe is a legal no-op.
                     if ((axi_awlen != 8'd0) || !axi_wlast) begin
                        resp_d  = AXI_RESP_SLVERR;
                        state_d = RESP;
                     end else if (axi_wstrb == 8'd0) begin
                        state_d = RESP;
                     end else begin
                        state_d = ADDR;
                     end
                  end else begin
                     id_d   = axi_arid;
                     addr_d = axi_araddr;
                     size_d = axi_arsize[1:0];
                     if (axi_arlen != 8'd0) begin
                        resp_d  = AXI_RESP_SLVERR;
                        state_d = RESP;
                     end else begin
                        state_d = ADDR;
                     end
                  end
               end
            end
            ADDR: begin
               if (ahb_hready) begin
                  state_d = DATA;
`ifdef AXI2AHB_POSTED_WR_EN
                  if (write_q) begin
                     bvalid_post_d = 1'b1;
                  end
`endif
               end
            end
            DATA: begin
               if (ahb_hresp) begin
                  err_seen_d = 1'b1;
               end
               if (ahb_hready) begin
                  if (!write_q) begin
                     rdata_d = ahb_hrdata;
                  end
`ifdef AXI2AHB_POSTED_WR_EN
                  if (write_q) begin
                     // Response already returned OKAY; an error can only be flagged.
                     if (err_seen_q || ahb_hresp) begin
                        wr_err_d = 1'b1;
                     end
                     state_d = IDLE;
                  end else begin
                     resp_d  = (err_seen_q || ahb_hresp) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                     state_d = RESP;
                  end
`else
                  resp_d  = (err_seen_q || ahb_hresp) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  state_d = RESP;
`endif
               end
            end
            RESP: begin
               if (write_q ? b_hs : r_hs) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and capture registers; reset drops any outstanding transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         last_was_write_q <= 1'b0;
         id_q             <= '0;
         addr_q           <= 32'd0;
         size_q           <= 2'd0;
         write_q          <= 1'b0;
         wdata_q          <= 64'd0;
         rdata_q          <= 64'd0;
         resp_q           <= AXI_RESP_OKAY;
         err_seen_q       <= 1'b0;
`ifdef AXI2AHB_POSTED_WR_EN
         bvalid_post_q    <= 1'b0;
         wr_err_q         <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         last_was_write_q <= last_was_write_d;
         id_q             <= id_d;
         addr_q           <= addr_d;
         size_q           <= size_d;
         write_q          <= write_d;
         wdata_q          <= wdata_d;
         rdata_q          <= rdata_d;
         resp_q           <= resp_d;
         err_seen_q       <= err_seen_d;
`ifdef AXI2AHB_POSTED_WR_EN
         bvalid_post_q    <= bvalid_post_d;
         wr_err_q         <= wr_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi4_to_ahb_master.sv
// Directed bench for axi4_to_ahb_master: table of single transactions plus
// hand-written sequences for arbitration, bus_clk_en gating and mid-transfer reset.
module tb_axi4_to_ahb_master;

`ifdef AXI2AHB_POSTED_WR_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_clk_en = 1'b1;
   logic        axi_awvalid = 1'b0, axi_awready;
   logic [0:0]  axi_awid = '0;
   logic [31:0] axi_awaddr = '0;
   logic [2:0]  axi_awsize = '0;
   logic [7:0]  axi_awlen = '0;
   logic        axi_wvalid = 1'b0, axi_wready;
   logic [63:0] axi_wdata = '0;
   logic [7:0]  axi_wstrb = '0;
   logic        axi_wlast = 1'b0;
   logic        axi_bvalid, axi_bready = 1'b0;
   logic [0:0]  axi_bid;
   logic [1:0]  axi_bresp;
   logic        axi_arvalid = 1'b0, axi_arready;
   logic [0:0]  axi_arid = '0;
   logic [31:0] axi_araddr = '0;
   logic [2:0]  axi_arsize = '0;
   logic [7:0]  axi_arlen = '0;
   logic        axi_rvalid, axi_rready = 1'b0;
   logic [0:0]  axi_rid;
   logic [63:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast;
   logic [31:0] ahb_haddr;
   logic [2:0]  ahb_hsize;
   logic [1:0]  ahb_htrans;
   logic        ahb_hwrite;
   logic [2:0]  ahb_hburst;
   logic [3:0]  ahb_hprot;
   logic        ahb_hmastlock;
   logic [63:0] ahb_hwdata;
   logic [63:0] ahb_hrdata = '0;
   logic        ahb_hready = 1'b1;
   logic        ahb_hresp = 1'b0;
   logic        ahb_wr_err;

   axi4_to_ahb_master #(.TAG(1)) dut (
      .clk(clk), .rst(rst), .bus_clk_en(bus_clk_en),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
      .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awlen(axi_awlen),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
      .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arlen(axi_arlen),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans),
      .ahb_hwrite(ahb_hwrite), .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot),
      .ahb_hmastlock(ahb_hmastlock), .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata),
      .ahb_hready(ahb_hready), .ahb_hresp(ahb_hresp), .ahb_wr_err(ahb_wr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- AHB slave model ----------------
   int          cfg_waits = 0;
   bit          cfg_err = 0;
   logic [63:0] cfg_rdata = '0;
   bit          s_en, s_nonseq, s_hready;
   bit          dp_active = 0;
   int          dp_cnt = 0;
   int          nonseq_cnt = 0;
   logic [31:0] last_haddr = '0;
   logic [2:0]  last_hsize = '0;
   logic        last_hwrite = 1'b0;
   logic [63:0] last_hwdata = '0;
   bit          wr_log[$];

   // Observe what the DUT will sample at the coming rising edge.
   always @(negedge clk) begin
      s_en     = bus_clk_en;
      s_nonseq = (ahb_htrans == 2'b10);
      s_hready = ahb_hready;
      if (!rst && s_en && s_nonseq && s_hready) begin
         nonseq_cnt++;
         last_haddr  = ahb_haddr;
         last_hsize  = ahb_hsize;
         last_hwrite = ahb_hwrite;
         wr_log.push_back(ahb_hwrite);
      end
      if (!rst && s_en && dp_active && s_hready) last_hwdata = ahb_hwdata;
   end

   // Advance the data phase and drive hready/hresp/hrdata for the next cycle.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         dp_active = 0;
      end else if (s_en) begin
         if (dp_active) begin
            if (s_hready) dp_active = 0;
            else dp_cnt++;
         end
         if (s_nonseq && s_hready) begin
            dp_active = 1;
            dp_cnt = 0;
         end
      end
      if (dp_active) begin
         if (cfg_err) begin
            ahb_hready = (dp_cnt >= 1);
            ahb_hresp  = 1'b1;
         end else begin
            ahb_hready = (dp_cnt >= cfg_waits);
            ahb_hresp  = 1'b0;
         end
         ahb_hrdata = cfg_rdata;
      end else begin
         ahb_hready = 1'b1;
         ahb_hresp  = 1'b0;
         ahb_hrdata = 64'd0;
      end
   end

   // ---------------- transaction table ----------------
   typedef struct {
      bit          w;
      logic [0:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [63:0] data;      // write data, or hrdata returned for a read
      logic [7:0]  strb;
      bit          last;
      int          waits;
      bit          err;
      logic [1:0]  exp_resp;
      int          exp_lat;   // cycles from accept to first response valid
      int          exp_ns;    // NONSEQ transfers expected
      logic [2:0]  exp_hsize;
   } txn_t;

   txn_t vec[10];

   task automatic issue(input txn_t t, output int lat, output logic [1:0] resp,
                        output logic [0:0] id, output logic [63:0] rdata, output bit timeout);
      int acc;
      int first;
      bit v;
      acc = -1;
      first = -1;
      resp = 2'bxx;
      id = 1'bx;
      rdata = 'x;
      @(posedge clk); #1;
      cfg_waits = t.waits;
      cfg_err   = t.err;
      cfg_rdata = t.data;
      if (t.w) begin
         axi_awvalid = 1'b1; axi_wvalid = 1'b1;
         axi_awid = t.id; axi_awaddr = t.addr; axi_awsize = t.size; axi_awlen = t.len;
         axi_wdata = t.data; axi_wstrb = t.strb; axi_wlast = t.last;
      end else begin
         axi_arvalid = 1'b1;
         axi_arid = t.id; axi_araddr = t.addr; axi_arsize = t.size; axi_arlen = t.len;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus_clk_en && ((t.w && axi_awready && axi_wready) || (!t.w && axi_arready))) begin
            acc = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
      axi_bready = 1'b1; axi_rready = 1'b1;
      if (acc >= 0) begin
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            v = t.w ? axi_bvalid : axi_rvalid;
            if (v && first < 0) begin
               first = cyc;
               resp  = t.w ? axi_bresp : axi_rresp;
               id    = t.w ? axi_bid : axi_rid;
               rdata = axi_rdata;
            end
            if (v && bus_clk_en) break;
         end
      end
      @(posedge clk); #1;
      axi_bready = 1'b0; axi_rready = 1'b0;
      timeout = (acc < 0) || (first < 0);
      lat = first - acc;
   endtask

   int          lat;
   logic [1:0]  resp;
   logic [0:0]  rid;
   logic [63:0] rd;
   bit          tmo;
   int          ns_before;
   int          log_base;
   int          nresp;
   bit          got;

   initial begin
      //          w  id    addr          size  len   data                   strb   last waits err resp   lat                 ns hsize
      vec[0] = '{1'b1, 1'b1, 32'h1000_0008, 3'd3, 8'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 0, 1'b0, 2'b00, POSTED ? 2 : 3, 1, 3'd3};
      vec[1] = '{1'b0, 1'b0, 32'h2000_0004, 3'd2, 8'd0, 64'h12345678_9ABCDEF0, 8'h00, 1'b0, 2, 1'b0, 2'b00, 5,              1, 3'd2};
      vec[2] = '{1'b0, 1'b1, 32'h3000_0000, 3'd3, 8'd0, 64'hAAAA5555_AAAA5555, 8'h00, 1'b0, 0, 1'b1, 2'b10, 4,              1, 3'd3};
      vec[3] = '{1'b0, 1'b0, 32'h3000_0010, 3'd3, 8'd0, 64'h0F1E2D3C_4B5A6978, 8'h00, 1'b0, 0, 1'b0, 2'b00, 3,              1, 3'd3};
      vec[4] = '{1'b1, 1'b1, 32'h5000_0000, 3'd3, 8'd3, 64'h01010101_01010101, 8'hFF, 1'b1, 0, 1'b0, 2'b10, 1,              0, 3'd0};
      vec[5] = '{1'b1, 1'b0, 32'h5000_0008, 3'd3, 8'd0, 64'h02020202_02020202, 8'h00, 1'b1, 0, 1'b0, 2'b00, 1,              0, 3'd0};
      vec[6] = '{1'b1, 1'b1, 32'h5000_0010, 3'd3, 8'd0, 64'h03030303_03030303, 8'hFF, 1'b0, 0, 1'b0, 2'b10, 1,              0, 3'd0};
      vec[7] = '{1'b0, 1'b1, 32'h6000_0000, 3'd3, 8'd1, 64'h04040404_04040404, 8'h00, 1'b0, 0, 1'b0, 2'b10, 1,              0, 3'd0};
      vec[8] = '{1'b1, 1'b0, 32'h4000_0002, 3'd1, 8'd0, 64'h00000000_BEEF0000, 8'h0C, 1'b1, 1, 1'b0, 2'b00, POSTED ? 2 : 4, 1, 3'd1};
      vec[9] = '{1'b1, 1'b1, 32'h7000_0000, 3'd6, 8'd0, 64'h11112222_33334444, 8'hF0, 1'b1, 0, 1'b1,
                 POSTED ? 2'b00 : 2'b10, POSTED ? 2 : 4, 1, 3'd2};

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_readys", {61'd0, axi_awready, axi_wready, axi_arready}, 64'd0);
      chk("rst_valids", {62'd0, axi_bvalid, axi_rvalid}, 64'd0);
      chk("rst_htrans", {62'd0, ahb_htrans}, 64'd0);
      chk("rst_haddr", {32'd0, ahb_haddr}, 64'd0);
      chk("rst_hwdata", ahb_hwdata, 64'd0);
      chk("rst_hsize_hwrite", {60'd0, ahb_hsize, ahb_hwrite}, 64'd0);
      chk("rst_rdata", axi_rdata, 64'd0);
      chk("rst_wr_err", {63'd0, ahb_wr_err}, 64'd0);
      chk("const_outputs", {53'd0, ahb_hburst, ahb_hprot, ahb_hmastlock, axi_rlast}, {53'd0, 3'b000, 4'b0011, 1'b0, 1'b1});
      @(posedge clk); #1;
      rst = 1'b0;

      // ---- arbitration: all valids held for four transactions ----
      cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 64'h0BADF00D_0BADF00D;
      log_base = wr_log.size();
      ns_before = nonseq_cnt;
      @(posedge clk); #1;
      axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
      axi_awid = 1'b0; axi_awaddr = 32'h8000_0000; axi_awsize = 3'd3; axi_awlen = 8'd0;
      axi_wdata = 64'h55555555_55555555; axi_wstrb = 8'hFF; axi_wlast = 1'b1;
      axi_arid = 1'b1; axi_araddr = 32'h9000_0000; axi_arsize = 3'd3; axi_arlen = 8'd0;
      axi_bready = 1'b1; axi_rready = 1'b1;
      nresp = 0;
      for (int i = 0; i < 80 && nresp < 4; i++) begin
         @(negedge clk);
         if (bus_clk_en && ((axi_bvalid && axi_bready) || (axi_rvalid && axi_rready))) nresp++;
      end
      @(posedge clk); #1;
      axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
      axi_bready = 1'b0; axi_rready = 1'b0;
      repeat (4) @(negedge clk);
      chk("arb_responses", 64'(nresp), 64'd4);
      chk("arb_nonseq_count", 64'(nonseq_cnt - ns_before), 64'd4);
      if (wr_log.size() >= log_base + 4) begin
         chk("arb_order", {60'd0, wr_log[log_base], wr_log[log_base+1], wr_log[log_base+2], wr_log[log_base+3]},
             {60'd0, 4'b1010});
      end else begin
         chk("arb_order_len", 64'(wr_log.size() - log_base), 64'd4);
      end
      $display("SEQ arbitration responses=%0d nonseq=%0d", nresp, nonseq_cnt - ns_before);

      // ---- table-driven single transactions ----
      for (int k = 0; k < 10; k++) begin
         ns_before = nonseq_cnt;
         issue(vec[k], lat, resp, rid, rd, tmo);
         repeat (4) @(negedge clk);
         $display("TXN %0d w=%0d addr=0x%08h resp=%0d lat=%0d nonseq=%0d",
                  k, vec[k].w, vec[k].addr, resp, lat, nonseq_cnt - ns_before);
         chk($sformatf("v%0d_timeout", k), {63'd0, tmo}, 64'd0);
         chk($sformatf("v%0d_resp", k), {62'd0, resp}, {62'd0, vec[k].exp_resp});
         chk($sformatf("v%0d_id", k), {63'd0, rid}, {63'd0, vec[k].id});
         chk($sformatf("v%0d_latency", k), 64'(lat), 64'(vec[k].exp_lat));
         chk($sformatf("v%0d_nonseq", k), 64'(nonseq_cnt - ns_before), 64'(vec[k].exp_ns));
         if (vec[k].exp_ns != 0) begin
            chk($sformatf("v%0d_haddr", k), {32'd0, last_haddr}, {32'd0, vec[k].addr});
            chk($sformatf("v%0d_hsize", k), {61'd0, last_hsize}, {61'd0, vec[k].exp_hsize});
            chk($sformatf("v%0d_hwrite", k), {63'd0, last_hwrite}, {63'd0, vec[k].w});
            if (vec[k].w) chk($sformatf("v%0d_hwdata", k), last_hwdata, vec[k].data);
            else if (!vec[k].err) chk($sformatf("v%0d_rdata", k), rd, vec[k].data);
         end
      end
      // Only the posted build reports the last write's AHB error through the sticky flag.
      chk("wr_err_after_table", {63'd0, ahb_wr_err}, {63'd0, POSTED});

      // ---- bus_clk_en toggling, rready held low ----
      cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 64'hA5A55A5A_01234567;
      @(posedge clk); #1;
      bus_clk_en = 1'b1;
      axi_arvalid = 1'b1; axi_arid = 1'b1; axi_araddr = 32'hB000_0008; axi_arsize = 3'd3; axi_arlen = 8'd0;
      axi_rready = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_clk_en && axi_arready) begin got = 1; break; end
         @(posedge clk); #1; bus_clk_en = ~bus_clk_en;
      end
      @(posedge clk); #1;
      axi_arvalid = 1'b0; bus_clk_en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (axi_rvalid) break;
         @(posedge clk); #1; bus_clk_en = ~bus_clk_en;
      end
      chk("en_accept_rvalid", {62'd0, got, axi_rvalid}, {62'd0, 2'b11});
      chk("en_rdata", axi_rdata, 64'hA5A55A5A_01234567);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1; bus_clk_en = ~bus_clk_en;
         @(negedge clk);
         chk($sformatf("hold%0d_rvalid", k), {63'd0, axi_rvalid}, 64'd1);
         chk($sformatf("hold%0d_rdata", k), axi_rdata, 64'hA5A55A5A_01234567);
      end
      @(posedge clk); #1; bus_clk_en = 1'b0; axi_rready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("masked_handshake_rvalid", {63'd0, axi_rvalid}, 64'd1);
      @(posedge clk); #1; bus_clk_en = 1'b1;
      @(posedge clk); #1; axi_rready = 1'b0;
      @(negedge clk);
      chk("after_handshake_rvalid", {63'd0, axi_rvalid}, 64'd0);
      $display("SEQ bus_clk_en read rdata=0x%016h", 64'hA5A55A5A_01234567);

      // ---- reset in the middle of a read data phase ----
      cfg_waits = 10; cfg_err = 1'b0; cfg_rdata = 64'hFEEDFACE_FEEDFACE;
      @(posedge clk); #1;
      axi_arvalid = 1'b1; axi_arid = 1'b0; axi_araddr = 32'hA000_0000; axi_arsize = 3'd3; axi_arlen = 8'd0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (axi_arready) begin got = 1; break; end
      end
      @(posedge clk); #1; axi_arvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b1;
      @(negedge clk);
      chk("midrst_accepted", {63'd0, got}, 64'd1);
      chk("midrst_htrans_rvalid", {61'd0, ahb_htrans, axi_rvalid}, 64'd0);
      chk("midrst_rdata", axi_rdata, 64'd0);
      chk("midrst_haddr", {32'd0, ahb_haddr}, 64'd0);
      chk("midrst_wr_err", {63'd0, ahb_wr_err}, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      ns_before = nonseq_cnt;
      issue(vec[3], lat, resp, rid, rd, tmo);
      repeat (2) @(negedge clk);
      $display("SEQ after reset read resp=%0d lat=%0d", resp, lat);
      chk("postrst_timeout", {63'd0, tmo}, 64'd0);
      chk("postrst_resp", {62'd0, resp}, 64'd0);
      chk("postrst_latency", 64'(lat), 64'd3);
      chk("postrst_rdata", rd, 64'h0F1E2D3C_4B5A6978);
      chk("postrst_nonseq", 64'(nonseq_cnt - ns_before), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
